// File: rtl/mraddr_ctrl_if.sv
// Memory-read address bus bundle: requester handshakes, memory handshake and
// returned data. master = requesters + memory side, slave = controller.
interface mraddr_ctrl_if;
  logic        fetch_req;
  logic        oper_req;
  logic [1:0]  oper_sel;
  logic [15:0] src;
  logic        mem_rd;
  logic        mem_rdy;
  logic [15:0] mem_data;
  logic [15:0] data_out;
  logic        fetch_ack;
  logic        oper_ack;
  logic        mem_err;
  logic        busy;

  modport master (
    output fetch_req, oper_req, oper_sel, mem_rdy, mem_data,
    input  src, mem_rd, data_out, fetch_ack, oper_ack, mem_err, busy
  );

  modport slave (
    input  fetch_req, oper_req, oper_sel, mem_rdy, mem_data,
    output src, mem_rd, data_out, fetch_ack, oper_ack, mem_err, busy
  );
endinterface

// File: rtl/mraddr_ctrl.sv
// Memory-read address controller: fair fetch/operand arbitration, SRC select
// generation and a bounded-wait read handshake with a one-cycle acknowledge.
module mraddr_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mraddr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, ACK} state_e;

  state_e      state_q, state_d;
  logic        oper_q, oper_d;
  logic [1:0]  sel_q, sel_d;
  logic        last_oper_q, last_oper_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] data_q, data_d;

  // On a tie the class that lost last time wins; a lone request always wins.
  logic grant_oper;
  assign grant_oper = bus.oper_req & (~bus.fetch_req | ~last_oper_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      oper_q      <= 1'b0;
      sel_q       <= 2'd0;
      last_oper_q <= 1'b1;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      data_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      oper_q      <= oper_d;
      sel_q       <= sel_d;
      last_oper_q <= last_oper_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    oper_d      = oper_q;
    sel_d       = sel_q;
    last_oper_d = last_oper_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (bus.fetch_req | bus.oper_req) begin
          state_d     = READ;
          oper_d      = grant_oper;
          last_oper_d = grant_oper;
          if (grant_oper) sel_d = bus.oper_sel;
          cnt_d       = 8'd0;
          err_d       = 1'b0;
        end
      end
      READ: begin
        // A response on the final wait cycle beats the timeout.
        if (bus.mem_rdy) begin
          data_d  = bus.mem_data;
          err_d   = 1'b0;
          state_d = ACK;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          data_d  = 16'hFFFF;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRC: bit7 bus enable, bit4 index group, bit3 member within group.
  logic in_read, grp, mbr;
  always_comb begin
    in_read       = (state_q == READ);
    grp           = in_read & oper_q & ((sel_q == 2'd1) | (sel_q == 2'd2));
    mbr           = in_read & oper_q & (sel_q != 2'd1);
    bus.src       = {8'h00, in_read, 2'b00, grp, mbr, 3'b000};
    bus.mem_rd    = in_read;
    bus.fetch_ack = (state_q == ACK) & ~oper_q;
    bus.oper_ack  = (state_q == ACK) & oper_q;
    bus.mem_err   = (state_q == ACK) & err_q;
    bus.busy      = (state_q != IDLE);
    bus.data_out  = data_q;
  end

endmodule
